// File: rtl/pipe_stage_elastic_reg_pkg.sv
// Shared pipeline definitions: elastic-stage state encoding and per-boundary payload layouts.
// The state encoding doubles as the entry count, so OCCUPANCY is the state itself.
package pipe_pkg;

  typedef enum logic [1:0] {
    PS_EMPTY = 2'd0,
    PS_ONE   = 2'd1,
    PS_TWO   = 2'd2
  } ps_state_e;

  // IF/ID: pc, instruction; no control bits
  localparam int IFID_W         = 64;
  localparam int IFID_INSTR_LSB = 0;
  localparam int IFID_PC_LSB    = 32;
  localparam logic [IFID_W-1:0] IFID_CTRL_MASK = '0;

  // EX/MEM: ctrl[4:0] = {mem_sel, mem_to_reg, mem_write, mem_read, reg_write}
  localparam int EXMEM_W          = 141;
  localparam int EXMEM_CTRL_LSB   = 0;
  localparam int EXMEM_CTRL_W     = 5;
  localparam int EXMEM_RD_LSB     = 5;
  localparam int EXMEM_FUNC3_LSB  = 10;
  localparam int EXMEM_ALU_LSB    = 13;
  localparam int EXMEM_RS2_LSB    = 45;
  localparam int EXMEM_PC_LSB     = 77;
  localparam int EXMEM_PC4_LSB    = 109;
  localparam logic [EXMEM_W-1:0] EXMEM_CTRL_MASK = {{(EXMEM_W-EXMEM_CTRL_W){1'b0}}, {EXMEM_CTRL_W{1'b1}}};

  // MEM/WB: ctrl[1:0] = {mem_to_reg, reg_write}, rd, alu result, load data
  localparam int MEMWB_W        = 71;
  localparam int MEMWB_CTRL_LSB = 0;
  localparam int MEMWB_RD_LSB   = 2;
  localparam int MEMWB_ALU_LSB  = 7;
  localparam int MEMWB_LOAD_LSB = 39;
  localparam logic [MEMWB_W-1:0] MEMWB_CTRL_MASK = {{(MEMWB_W-2){1'b0}}, 2'b11};

endpackage

// File: rtl/pipe_stage_elastic_reg.sv
// Elastic pipeline register with valid/ready handshake, optional 2-entry skid,
// synchronous flush and bubble masking of control bits on the output.
module pipe_stage_elastic_reg
  import pipe_pkg::*;
#(
  parameter int                DATA_W    = EXMEM_W,
  parameter logic [DATA_W-1:0] CTRL_MASK = {DATA_W{1'b0}},
  parameter int                SKID      = 1
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              FLUSH,
  input  logic              IN_VALID,
  output logic              IN_READY,
  input  logic [DATA_W-1:0] IN_DATA,
  output logic              OUT_VALID,
  input  logic              OUT_READY,
  output logic [DATA_W-1:0] OUT_DATA,
  output logic [1:0]        OCCUPANCY
);

  ps_state_e         state_q, state_d;
  logic [DATA_W-1:0] main_q, main_d;
  logic [DATA_W-1:0] skid_q, skid_d;
  logic              in_ready_q, in_ready_d;
  logic              in_xfer, out_xfer;

  assign OUT_VALID = (state_q != PS_EMPTY);
  assign OUT_DATA  = OUT_VALID ? main_q : (main_q & ~CTRL_MASK);
  assign OCCUPANCY = state_q;

  // in_ready_q is low only during reset in the single-entry build, so it also gates the first cycle
  assign IN_READY = (SKID != 0) ? in_ready_q : (in_ready_q & (!OUT_VALID | OUT_READY));

  assign in_xfer  = IN_VALID & IN_READY;
  assign out_xfer = OUT_VALID & OUT_READY;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (FLUSH) begin
      state_d = PS_EMPTY;
    end else begin
      case (state_q)
        PS_EMPTY: begin
          if (in_xfer) begin
            state_d = PS_ONE;
            main_d  = IN_DATA;
          end
        end
        PS_ONE: begin
          if (in_xfer && out_xfer) begin
            main_d = IN_DATA;
          end else if (out_xfer) begin
            state_d = PS_EMPTY;
          end else if (in_xfer && (SKID != 0)) begin
            state_d = PS_TWO;
            skid_d  = IN_DATA;
          end
        end
        PS_TWO: begin
          if (out_xfer) begin
            state_d = PS_ONE;
            main_d  = skid_q;
          end
        end
        default: state_d = PS_EMPTY;
      endcase
    end
    in_ready_d = (state_d != PS_TWO);
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q    <= PS_EMPTY;
      main_q     <= '0;
      skid_q     <= '0;
      in_ready_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      main_q     <= main_d;
      skid_q     <= skid_d;
      in_ready_q <= in_ready_d;
    end
  end

endmodule

// File: tb/tb_pipe_stage_elastic_reg.sv
// Drives a skid and a single-entry instance with the same stimulus and checks
// both against queue-based FIFO models of the handshake rules.
module tb_pipe_stage_elastic_reg;

  localparam int          W    = 32;
  localparam logic [W-1:0] MASK = 32'h1;

  logic         CLK = 1'b0;
  logic         RESET, FLUSH, IN_VALID, OUT_READY;
  logic [W-1:0] IN_DATA;
  logic         in_ready1, out_valid1, in_ready0, out_valid0;
  logic [W-1:0] out_data1, out_data0;
  logic [1:0]   occ1, occ0;

  always #5 CLK = ~CLK;

  pipe_stage_elastic_reg #(.DATA_W(W), .CTRL_MASK(MASK), .SKID(1)) dut1 (
    .CLK(CLK), .RESET(RESET), .FLUSH(FLUSH), .IN_VALID(IN_VALID), .IN_READY(in_ready1),
    .IN_DATA(IN_DATA), .OUT_VALID(out_valid1), .OUT_READY(OUT_READY), .OUT_DATA(out_data1),
    .OCCUPANCY(occ1));

  pipe_stage_elastic_reg #(.DATA_W(W), .CTRL_MASK(MASK), .SKID(0)) dut0 (
    .CLK(CLK), .RESET(RESET), .FLUSH(FLUSH), .IN_VALID(IN_VALID), .IN_READY(in_ready0),
    .IN_DATA(IN_DATA), .OUT_VALID(out_valid0), .OUT_READY(OUT_READY), .OUT_DATA(out_data0),
    .OCCUPANCY(occ0));

  int pass_cnt = 0;
  int fail_cnt = 0;
  int tot_cnt  = 0;

  // Model: the stage is a FIFO of capacity 2 (skid) or 1 (single); "last head" is what
  // the output shows, masked, once the FIFO is empty.
  logic [W-1:0] q1[$];
  logic [W-1:0] q0[$];
  logic [W-1:0] last1 = '0, last0 = '0;
  bit           rdy_ok = 0;
  bit           known  = 0;
  bit           acc1   = 0;

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    tot_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step(input bit rst, input bit fl, input bit iv, input logic [W-1:0] d, input bit ordy);
    bit ix1, ox1, ix0, ox0, er1, er0;
    logic [W-1:0] ed1, ed0;
    RESET = rst; FLUSH = fl; IN_VALID = iv; IN_DATA = d; OUT_READY = ordy;
    #1;
    er1 = rdy_ok && (q1.size() < 2);
    er0 = rdy_ok && ((q0.size() == 0) || ordy);
    ed1 = (q1.size() > 0) ? q1[0] : (last1 & ~MASK);
    ed0 = (q0.size() > 0) ? q0[0] : (last0 & ~MASK);
    if (known) begin
      chk("skid.in_ready",  {31'd0, in_ready1},  {31'd0, er1});
      chk("skid.out_valid", {31'd0, out_valid1}, {31'd0, q1.size() > 0});
      chk("skid.out_data",  out_data1, ed1);
      chk("skid.occupancy", {30'd0, occ1}, q1.size());
      chk("single.in_ready",  {31'd0, in_ready0},  {31'd0, er0});
      chk("single.out_valid", {31'd0, out_valid0}, {31'd0, q0.size() > 0});
      chk("single.out_data",  out_data0, ed0);
      chk("single.occupancy", {30'd0, occ0}, q0.size());
    end
    ix1 = iv && er1;  ox1 = (q1.size() > 0) && ordy;
    ix0 = iv && er0;  ox0 = (q0.size() > 0) && ordy;
    @(posedge CLK); #1;
    if (rst) begin
      q1.delete(); q0.delete(); last1 = '0; last0 = '0; rdy_ok = 0;
    end else begin
      if (ox1) void'(q1.pop_front());
      if (ox0) void'(q0.pop_front());
      if (fl) begin
        q1.delete(); q0.delete();
      end else begin
        if (ix1) q1.push_back(d);
        if (ix0) q0.push_back(d);
      end
      if (q1.size() > 0) last1 = q1[0];
      if (q0.size() > 0) last0 = q0[0];
      rdy_ok = 1;
    end
    acc1  = ix1 && !rst;
    known = 1;
    $display("t=%0t rst=%0b fl=%0b iv=%0b d=%h ordy=%0b | skid v=%0b d=%h occ=%0d | single v=%0b d=%h occ=%0d",
             $time, rst, fl, iv, d, ordy, out_valid1, out_data1, occ1, out_valid0, out_data0, occ0);
  endtask

  initial begin
    logic [W-1:0] pend;
    bit           pv;
    // reset then stream
    step(1, 0, 0, 32'h0, 1);
    step(1, 0, 0, 32'h0, 1);
    step(0, 0, 0, 32'h0, 1);
    step(0, 0, 1, 32'h1, 1);
    step(0, 0, 1, 32'h2, 1);
    step(0, 0, 1, 32'h3, 1);
    step(0, 0, 0, 32'h0, 1);
    step(0, 0, 0, 32'h0, 1);
    // back-pressure: B goes to skid, C held upstream
    step(0, 0, 1, 32'hA, 1);
    step(0, 0, 1, 32'hB, 0);
    step(0, 0, 1, 32'hC, 0);
    step(0, 0, 1, 32'hC, 1);
    step(0, 0, 1, 32'hC, 1);
    step(0, 0, 0, 32'h0, 1);
    step(0, 0, 0, 32'h0, 1);
    // flush in TWO with an offered payload, then flush in ONE where IN_READY is high
    step(0, 0, 1, 32'h11, 0);
    step(0, 0, 1, 32'h12, 0);
    step(0, 1, 1, 32'hD, 0);
    step(0, 0, 0, 32'h0, 1);
    step(0, 0, 1, 32'h21, 1);
    step(0, 1, 1, 32'h22, 1);
    step(0, 0, 0, 32'h0, 1);
    // bubble mask on drain
    step(0, 0, 1, 32'h123456FF, 1);
    step(0, 0, 0, 32'h0, 1);
    step(0, 0, 0, 32'h0, 0);
    chk("bubble.skid_data", out_data1, 32'h123456FE);
    // single-entry replace with no bubble
    step(0, 0, 1, 32'h5, 1);
    step(0, 0, 1, 32'h6, 1);
    step(0, 0, 0, 32'h0, 1);
    step(0, 0, 0, 32'h0, 1);
    // reset together with flush while stalled in TWO
    step(0, 0, 1, 32'h31, 0);
    step(0, 0, 1, 32'h32, 0);
    step(1, 1, 1, 32'h33, 0);
    step(0, 0, 0, 32'h0, 1);
    step(0, 0, 1, 32'h44, 1);
    step(0, 0, 0, 32'h0, 1);
    step(0, 0, 0, 32'h0, 1);
    // randomized traffic with upstream holding its payload until accepted
    pv = 0;
    pend = '0;
    for (int i = 0; i < 400; i++) begin
      if (!pv) begin
        pv   = ($urandom_range(0, 3) != 0);
        pend = $urandom;
      end
      step($urandom_range(0, 99) == 0, $urandom_range(0, 19) == 0, pv, pend, $urandom_range(0, 3) != 0);
      if (acc1) pv = 0;
    end
    step(0, 0, 0, 32'h0, 1);
    step(0, 0, 0, 32'h0, 1);
    step(0, 0, 0, 32'h0, 1);
    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end

endmodule
